// File: rtl/vram_arb_pkg.sv
// Shared constants and types for the VRAM write arbiter.
// Imported by the fill sequencer and the arbiter top.
package vram_arb_pkg;

   localparam int C_AW       = 10;
   localparam int C_DW       = 8;
   localparam int VRAM_DEPTH = 1024;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

endpackage

// File: rtl/vram_fill_seq.sv
// Fill sequencer: latches a fill range and walks the pointer
// one cell per grant, wrapping at the top of VRAM.
module vram_fill_seq #(
   parameter int C_AW = vram_arb_pkg::C_AW,
   parameter int C_DW = vram_arb_pkg::C_DW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            gnt,
   input  logic [C_AW-1:0] sa,
   input  logic [C_AW-1:0] ea,
   input  logic [C_DW-1:0] dat,
   output logic            req,
   output logic            busy,
   output logic            done,
   output logic [C_AW-1:0] addr,
   output logic [C_DW-1:0] data
);

   import vram_arb_pkg::*;

   localparam logic [C_AW-1:0] PTR_ONE = {{(C_AW-1){1'b0}}, 1'b1};

   fill_state_t     state_q, state_d;
   logic [C_AW-1:0] ptr_q, ptr_d;
   logic [C_AW-1:0] ea_q, ea_d;
   logic [C_DW-1:0] dat_q, dat_d;
   logic            done_q, done_d;

   // Next state: start is only honoured in IDLE, so a restart
   // during a fill leaves the latched range untouched.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ea_d    = ea_q;
      dat_d   = dat_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d   = sa;
               ea_d    = ea;
               dat_d   = dat;
               state_d = FILL;
            end
         end
         FILL: begin
            if (gnt) begin
               ptr_d = ptr_q + PTR_ONE;
               if (ptr_q == ea_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and pointer registers; reset aborts any fill silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         ea_q    <= '0;
         dat_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ea_q    <= ea_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
      end
   end

   assign req  = (state_q == FILL);
   assign busy = (state_q == FILL);
   assign done = done_q;
   assign addr = ptr_q;
   assign data = dat_q;

endmodule

// File: rtl/vram_wr_arb.sv
// VRAM write arbiter: shares pixel-clock write slots between
// CPU writes and the fill sequencer, round-robin on a tie.
module vram_wr_arb #(
   parameter int C_AW = vram_arb_pkg::C_AW,
   parameter int C_DW = vram_arb_pkg::C_DW
) (
   input  logic            CK_i,
   input  logic            RST_i,
   input  logic            CK_EE_i,
   input  logic            BLANK_i,
   input  logic            BUS_BLANK_ONLY,
   input  logic            CPU_REQ_i,
   input  logic [C_AW-1:0] CPU_WAs_i,
   input  logic [C_DW-1:0] CPU_WDs_i,
   output logic            CPU_ACK_o,
   input  logic            FILL_START_i,
   input  logic [C_AW-1:0] FILL_SAs_i,
   input  logic [C_AW-1:0] FILL_EAs_i,
   input  logic [C_DW-1:0] FILL_DATs_i,
   output logic            FILL_BUSY_o,
   output logic            FILL_DONE_o,
   output logic [C_AW-1:0] VRAM_WAs_o,
   output logic [C_DW-1:0] VRAM_WDs_o,
   output logic            VRAM_WE_o
);

   import vram_arb_pkg::*;

   logic            slot;
   logic            cpu_pend;
   logic            fill_pend;
   logic            gnt_cpu;
   logic            gnt_fill;
   logic            last_fill;
   logic [C_AW-1:0] fill_addr;
   logic [C_DW-1:0] fill_data;

   vram_fill_seq #(
      .C_AW (C_AW),
      .C_DW (C_DW)
   ) u_fill (
      .clk   (CK_i),
      .rst   (RST_i),
      .start (FILL_START_i),
      .gnt   (gnt_fill),
      .sa    (FILL_SAs_i),
      .ea    (FILL_EAs_i),
      .dat   (FILL_DATs_i),
      .req   (fill_pend),
      .busy  (FILL_BUSY_o),
      .done  (FILL_DONE_o),
      .addr  (fill_addr),
      .data  (fill_data)
   );

   // An ack still on the output means the current request level
   // belongs to the write just issued, not a new one.
   assign slot     = CK_EE_i & (~BUS_BLANK_ONLY | BLANK_i);
   assign cpu_pend = CPU_REQ_i & ~CPU_ACK_o;

   // Grant at most one requester per slot; on a tie the one not
   // served last wins.
   always_comb begin
      gnt_cpu  = 1'b0;
      gnt_fill = 1'b0;
      if (slot) begin
         if (cpu_pend && fill_pend) begin
            gnt_cpu  = last_fill;
            gnt_fill = ~last_fill;
         end else begin
            gnt_cpu  = cpu_pend;
            gnt_fill = fill_pend;
         end
      end
   end

   // Write port and ack registers; the write port only moves on
   // pixel-enable cycles so the VRAM sees a stable word per pixel.
   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         VRAM_WE_o  <= 1'b0;
         VRAM_WAs_o <= '0;
         VRAM_WDs_o <= '0;
         CPU_ACK_o  <= 1'b0;
         last_fill  <= 1'b1;
      end else begin
         CPU_ACK_o <= gnt_cpu;
         if (gnt_cpu || gnt_fill) begin
            last_fill <= gnt_fill;
         end
         if (CK_EE_i) begin
            VRAM_WE_o <= gnt_cpu | gnt_fill;
            if (gnt_cpu) begin
               VRAM_WAs_o <= CPU_WAs_i;
               VRAM_WDs_o <= CPU_WDs_i;
            end else if (gnt_fill) begin
               VRAM_WAs_o <= fill_addr;
               VRAM_WDs_o <= fill_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_vram_wr_arb.sv
// Directed bench for vram_wr_arb with a write scoreboard.
// Expected writes are queued as stimulus is applied.
module tb_vram_wr_arb;

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
      logic       cpu;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ee = 1'b0;
   logic       blank = 1'b0;
   logic       blank_only = 1'b0;
   logic       cpu_req = 1'b0;
   logic [9:0] cpu_wa = '0;
   logic [7:0] cpu_wd = '0;
   logic       cpu_ack;
   logic       fill_start = 1'b0;
   logic [9:0] fill_sa = '0;
   logic [9:0] fill_ea = '0;
   logic [7:0] fill_dat = '0;
   logic       fill_busy;
   logic       fill_done;
   logic [9:0] wa;
   logic [7:0] wd;
   logic       we;

   int   n_vec = 0;
   int   n_err = 0;
   int   ph = 0;
   int   cpu_left = 0;
   exp_t sb[$];
   logic       exp_we = 1'b0;
   logic [9:0] exp_wa = '0;
   logic [7:0] exp_wd = '0;

   always #5 clk = ~clk;

   vram_wr_arb #(
      .C_AW (10),
      .C_DW (8)
   ) dut (
      .CK_i           (clk),
      .RST_i          (rst),
      .CK_EE_i        (ee),
      .BLANK_i        (blank),
      .BUS_BLANK_ONLY (blank_only),
      .CPU_REQ_i      (cpu_req),
      .CPU_WAs_i      (cpu_wa),
      .CPU_WDs_i      (cpu_wd),
      .CPU_ACK_o      (cpu_ack),
      .FILL_START_i   (fill_start),
      .FILL_SAs_i     (fill_sa),
      .FILL_EAs_i     (fill_ea),
      .FILL_DATs_i    (fill_dat),
      .FILL_BUSY_o    (fill_busy),
      .FILL_DONE_o    (fill_done),
      .VRAM_WAs_o     (wa),
      .VRAM_WDs_o     (wd),
      .VRAM_WE_o      (we)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard monitor, sampled 1 time unit after each edge.
   always @(posedge clk) begin : mon
      logic e_s;
      logic r_s;
      exp_t e;
      e_s = ee;
      r_s = rst;
      #1;
      if (r_s) begin
         exp_we = 1'b0;
      end else if (e_s) begin
         if (we === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_write", 32'(we), 32'd0);
               exp_we = 1'b0;
            end else begin
               e = sb.pop_front();
               chk("wr_addr", 32'(wa), 32'(e.addr));
               chk("wr_data", 32'(wd), 32'(e.data));
               chk("cpu_ack", 32'(cpu_ack), 32'(e.cpu));
               chk("fill_done", 32'(fill_done), 32'(e.done));
               exp_we = 1'b1;
               exp_wa = e.addr;
               exp_wd = e.data;
            end
         end else begin
            exp_we = 1'b0;
            chk("ack_no_write", 32'(cpu_ack), 32'd0);
            chk("done_no_write", 32'(fill_done), 32'd0);
         end
      end else begin
         chk("we_hold", 32'(we), 32'(exp_we));
         if (exp_we) begin
            chk("wa_hold", 32'(wa), 32'(exp_wa));
            chk("wd_hold", 32'(wd), 32'(exp_wd));
         end
         chk("ack_width", 32'(cpu_ack), 32'd0);
         chk("done_width", 32'(fill_done), 32'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // One negedge step; drives the pixel enable and drops the CPU
   // request once the requested number of acks has been seen.
   task automatic tick();
      @(negedge clk);
      if (cpu_ack === 1'b1 && cpu_left > 0) begin
         cpu_left--;
         if (cpu_left == 0) cpu_req = 1'b0;
      end
      ph = (ph + 1) % 4;
      ee = (ph == 3);
   endtask

   task automatic to_slot();
      do tick(); while (!ee);
   endtask

   task automatic idle(input int slots);
      int k = 0;
      while (k < slots) begin
         tick();
         if (ee) k++;
      end
   endtask

   task automatic pulse_start();
      fill_start = 1'b1;
      tick();
      fill_start = 1'b0;
   endtask

   task automatic push_cpu(input logic [9:0] a, input logic [7:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.cpu  = 1'b1;
      e.done = 1'b0;
      sb.push_back(e);
   endtask

   task automatic push_fill_one(input int a, input logic [7:0] d,
                                input logic last);
      exp_t e;
      e.addr = 10'(a % 1024);
      e.data = d;
      e.cpu  = 1'b0;
      e.done = last;
      sb.push_back(e);
   endtask

   task automatic push_fill(input int sa, input int ea,
                            input logic [7:0] d);
      int cnt = ((ea - sa + 1024) % 1024) + 1;
      for (int i = 0; i < cnt; i++) begin
         push_fill_one(sa + i, d, i == cnt - 1);
      end
   endtask

   task automatic drain(input string tag, input int exp_slots);
      int n = ee ? 1 : 0;
      while (sb.size() != 0 && n <= exp_slots + 8) begin
         tick();
         if (ee) n++;
      end
      chk({"drain_", tag}, 32'(sb.size()), 32'd0);
      chk({"slots_", tag}, 32'(n), 32'(exp_slots));
      sb.delete();
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_wa", 32'(wa), 32'd0);
      chk("rst_wd", 32'(wd), 32'd0);
      chk("rst_ack", 32'(cpu_ack), 32'd0);
      chk("rst_busy", 32'(fill_busy), 32'd0);
      chk("rst_done", 32'(fill_done), 32'd0);

      // Single CPU write.
      to_slot();
      tick();
      cpu_wa = 10'h123;
      cpu_wd = 8'h41;
      push_cpu(10'h123, 8'h41);
      cpu_left = 1;
      cpu_req = 1'b1;
      drain("cpu_single", 1);
      idle(2);
      chk("cpu_req_dropped", 32'(cpu_req), 32'd0);

      // Wrapping fill with an ignored restart.
      to_slot();
      tick();
      fill_sa  = 10'h3FE;
      fill_ea  = 10'h001;
      fill_dat = 8'h20;
      push_fill(32'h3FE, 32'h001, 8'h20);
      pulse_start();
      chk("busy_wrap", 32'(fill_busy), 32'd1);
      fill_sa  = 10'h100;
      fill_ea  = 10'h100;
      fill_dat = 8'h55;
      pulse_start();
      drain("fill_wrap", 4);
      chk("idle_wrap", 32'(fill_busy), 32'd0);
      idle(2);

      // CPU held high during a fill: strict alternation.
      to_slot();
      tick();
      cpu_wa = 10'h055;
      cpu_wd = 8'h43;
      cpu_left = 4;
      cpu_req = 1'b1;
      fill_sa  = 10'h000;
      fill_ea  = 10'h003;
      fill_dat = 8'h2E;
      for (int i = 0; i < 4; i++) begin
         push_cpu(10'h055, 8'h43);
         push_fill_one(i, 8'h2E, i == 3);
      end
      pulse_start();
      drain("interleave", 8);
      chk("idle_interleave", 32'(fill_busy), 32'd0);
      idle(2);

      // Fill start coinciding with a CPU slot; single-cell fill.
      to_slot();
      cpu_wa = 10'h2AA;
      cpu_wd = 8'h5A;
      cpu_left = 1;
      cpu_req = 1'b1;
      fill_sa  = 10'h1C7;
      fill_ea  = 10'h1C7;
      fill_dat = 8'h61;
      push_cpu(10'h2AA, 8'h5A);
      push_fill(32'h1C7, 32'h1C7, 8'h61);
      pulse_start();
      drain("same_slot", 1);
      idle(2);

      // Writes gated to blanking; both requests held meanwhile.
      to_slot();
      tick();
      blank_only = 1'b1;
      blank = 1'b0;
      cpu_wa = 10'h200;
      cpu_wd = 8'h7E;
      cpu_left = 1;
      cpu_req = 1'b1;
      fill_sa  = 10'h010;
      fill_ea  = 10'h010;
      fill_dat = 8'h11;
      push_cpu(10'h200, 8'h7E);
      push_fill(32'h010, 32'h010, 8'h11);
      pulse_start();
      idle(100);
      chk("blank_held", 32'(sb.size()), 32'd2);
      tick();
      blank = 1'b1;
      drain("blank", 2);
      blank_only = 1'b0;
      blank = 1'b0;
      idle(2);

      // Reset mid-fill, then a fresh fill.
      to_slot();
      tick();
      fill_sa  = 10'h000;
      fill_ea  = 10'h00F;
      fill_dat = 8'h33;
      push_fill_one(0, 8'h33, 1'b0);
      push_fill_one(1, 8'h33, 1'b0);
      pulse_start();
      drain("pre_reset", 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_we", 32'(we), 32'd0);
      chk("mid_rst_wa", 32'(wa), 32'd0);
      chk("mid_rst_wd", 32'(wd), 32'd0);
      chk("mid_rst_busy", 32'(fill_busy), 32'd0);
      chk("mid_rst_done", 32'(fill_done), 32'd0);
      idle(5);
      chk("no_write_after_rst", 32'(sb.size()), 32'd0);
      to_slot();
      tick();
      fill_sa  = 10'h3A0;
      fill_ea  = 10'h3A2;
      fill_dat = 8'h77;
      push_fill(32'h3A0, 32'h3A2, 8'h77);
      pulse_start();
      chk("busy_restart", 32'(fill_busy), 32'd1);
      drain("restart", 3);
      chk("idle_restart", 32'(fill_busy), 32'd0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vram_wr_arb.md
VRAM_WR_ARB -- requirements
Module: vram_wr_arb

Interface
REQ-001 Parameter C_AW, default 10, is the VRAM address width (1024 character cells).
REQ-002 Parameter C_DW, default 8, is the VRAM data width (character code).
REQ-003 CK_i  in  1  system clock (NFSC clock domain).
REQ-004 RST_i  in  1  reset: synchronous and active-high.
REQ-005 CK_EE_i  in  1  pixel clock enable (1 of every 4 CK_i cycles).
REQ-006 BLANK_i  in  1  1 = video blanking interval, from the NTSC timing generator.
REQ-007 BUS_BLANK_ONLY  in  1  1 = VRAM writes are permitted only while BLANK_i=1.
REQ-008 CPU_REQ_i  in  1  CPU write request, level.
REQ-009 CPU_WAs_i  in  C_AW  CPU write address, stable while CPU_REQ_i=1.
REQ-010 CPU_WDs_i  in  C_DW  CPU write data, stable while CPU_REQ_i=1.
REQ-011 CPU_ACK_o  out  1  one-CK_i pulse when the CPU write has been issued.
REQ-012 FILL_START_i  in  1  one-cycle pulse that starts a fill.
REQ-013 FILL_SAs_i / FILL_EAs_i  in  C_AW each  fill start address and end address, inclusive.
REQ-014 FILL_DATs_i  in  C_DW  fill character code.
REQ-015 FILL_BUSY_o  out  1  fill in progress.
REQ-016 FILL_DONE_o  out  1  one-CK_i pulse when the last fill write is issued.
REQ-017 VRAM_WAs_o / VRAM_WDs_o / VRAM_WE_o  out  C_AW / C_DW / 1  write port to the character generator VRAM.

Function
REQ-018 Write slot: a CK_i cycle with CK_EE_i=1 and (BUS_BLANK_ONLY=0 or BLANK_i=1); at most one grant per slot.
REQ-019 Pending requests: CPU when CPU_REQ_i=1 and no CPU_ACK_o is in flight; fill when the FSM is in FILL.
REQ-020 Single pending requester: that requester is granted.
REQ-021 Both pending: round-robin, the requester not granted last wins; the other waits for the next slot.
REQ-022 Grant in slot cycle N:
  - VRAM_WE_o=1 with the granted address/data, registered, valid from N+1;
  - VRAM_* outputs update only on CK_EE_i=1 cycles and are held between them;
  - a slot with no grant drives VRAM_WE_o=0 at the next CK_EE_i update.
REQ-023 CPU_ACK_o=1 in cycle N+1 for exactly one cycle; if CPU_REQ_i is still 1 in the next slot, it is a new request using the current address/data.
REQ-024 CPU_REQ_i dropped before its grant: no write, no ack.
REQ-025 FSM state IDLE: FILL_START_i=1 latches SA, EA and DAT, sets pointer=SA and moves to FILL; FILL_BUSY_o=1 from the next cycle.
REQ-026 FSM state FILL: each fill grant writes to pointer, then pointer=pointer+1 mod 2^C_AW.
REQ-027 FILL ends when the granted pointer equals EA:
  - next state IDLE;
  - FILL_DONE_o=1 in N+1;
  - FILL_BUSY_o=0 from N+1.
REQ-028 Fill address boundaries:
  - SA>EA wraps 1023->0, total writes = (EA-SA+1024) mod 1024 + 1;
  - SA==EA gives exactly one write.
REQ-029 FILL_START_i while in FILL is ignored; latched parameters are unaffected.
REQ-030 FILL_START_i in the same cycle as a slot with CPU pending: CPU is granted in that slot; the fill starts in the next slot.
REQ-031 A change of BUS_BLANK_ONLY or BLANK_i takes effect at the next slot evaluation; pending requests are held and never dropped.

Reset
REQ-032 RST_i=1 at a CK_i edge forces:
  - outputs VRAM_WAs_o=0, VRAM_WDs_o=0, VRAM_WE_o=0, CPU_ACK_o=0, FILL_BUSY_o=0, FILL_DONE_o=0;
  - state IDLE, pointer=0, round-robin last=FILL (so CPU wins the first tie).
REQ-033 Reset during a fill aborts it; no FILL_DONE_o is issued.

Structure
REQ-034 Shared package vram_arb_pkg holds C_AW, C_DW, VRAM depth 1024 and the FSM state type {IDLE, FILL}.
REQ-035 The fill FSM and pointer form one sub-module, vram_fill_seq; arbitration and output registers stay in vram_wr_arb.

Verification
REQ-036 CK_EE every 4th cycle, BUS_BLANK_ONLY=0, CPU write 0x123<-0x41 -> VRAM_WE_o=1, WAs=0x123, WDs=0x41 one cycle after the slot, held 4 cycles; CPU_ACK_o pulses once.
REQ-037 Fill SA=0x3FE, EA=0x001, DAT=0x20 -> writes to 0x3FE, 0x3FF, 0x000, 0x001 on 4 consecutive slots; FILL_DONE_o pulses with the 0x001 write.
REQ-038 CPU_REQ_i held high during fill 0x000..0x003 -> writes alternate CPU, fill, CPU, fill...; fill completes in 8 slots.
REQ-039 BUS_BLANK_ONLY=1, BLANK_i=0 for 100 slots, then 1 -> no VRAM_WE_o until BLANK_i=1; then pending CPU write first.
REQ-040 RST_i pulsed after 2 writes of fill 0x000..0x00F -> all outputs 0, FILL_BUSY_o=0, no FILL_DONE_o; a new FILL_START_i is accepted.
